// File: rtl/fsm_adc.sv
// -----------------------------------------------------------------------------
// fsm_adc
//
// DRP controller sitting between the ADC capture logic and the XADC primitive
// wrapper. While `rd` is high every end-of-conversion pulse triggers a DRP read
// of the status register of the converted channel. The raw word is returned on
// `data_out` together with a one-cycle `valid` strobe. Single register writes
// are issued on `wr`.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-low reset
//   rd          in   level: while high each `eoc` starts a DRP read
//   wr          in   write request, sampled in IDLE
//   addr        in   DRP write address
//   data_in     in   DRP write data
//   data_out    out  last word read from the DRP
//   valid       out  one-cycle strobe: a DRP access completed
//   jtaglocked  in   high blocks every new DRP access
//   busy        in   XADC conversion busy (informational, unused)
//   drdy        in   DRP access complete
//   eoc         in   end-of-conversion pulse
//   eos         in   end-of-sequence pulse (unused)
//   channel     in   channel of the finished conversion
//   dout        in   DRP read data
//   dwe         out  DRP write enable
//   den         out  DRP enable strobe
//   daddr       out  DRP address
//   din         out  DRP write data
//   state_dbg   out  current FSM state (IDLE=0, RD_WAIT=1, WR_WAIT=2)
//
// DRP handshake: an access starts with `den` high for exactly one cycle (with
// `dwe` high for a write); `daddr`/`din` stay stable until the next access. The
// access completes when `drdy` is sampled high in the matching wait state.
// `drdy` outside a wait state has no effect. If `drdy` does not arrive within
// TIMEOUT cycles the access is abandoned silently. All outputs are registered.
// -----------------------------------------------------------------------------
module fsm_adc #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  jtaglocked,
    input  logic                  busy,
    input  logic                  drdy,
    input  logic                  eoc,
    input  logic                  eos,
    input  logic [4:0]            channel,
    input  logic [DATA_WIDTH-1:0] dout,
    output logic                  dwe,
    output logic                  den,
    output logic [ADDR_WIDTH-1:0] daddr,
    output logic [DATA_WIDTH-1:0] din,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0]  data_out_d;
    logic                   valid_d, den_d, dwe_d;
    logic [ADDR_WIDTH-1:0]  daddr_d;
    logic [DATA_WIDTH-1:0]  din_d;

    // busy and eos carry no meaning for this controller.
    logic unused_inputs;
    assign unused_inputs = ^{busy, eos};

    assign cnt_inc   = cnt_q + 1'b1;
    assign state_dbg = state_q;

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            den      <= 1'b0;
            dwe      <= 1'b0;
            daddr    <= '0;
            din      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_out <= data_out_d;
            valid    <= valid_d;
            den      <= den_d;
            dwe      <= dwe_d;
            daddr    <= daddr_d;
            din      <= din_d;
        end
    end

    // Next-state and next-output logic. den/dwe/valid default low so each is a
    // single-cycle strobe; address, write data and read data hold by default.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out;
        valid_d    = 1'b0;
        den_d      = 1'b0;
        dwe_d      = 1'b0;
        daddr_d    = daddr;
        din_d      = din;

        case (state_q)
            IDLE: begin
                // A write wins over a simultaneous read trigger; that eoc is lost.
                if (!jtaglocked) begin
                    if (wr) begin
                        den_d   = 1'b1;
                        dwe_d   = 1'b1;
                        daddr_d = addr;
                        din_d   = data_in;
                        cnt_d   = '0;
                        state_d = WR_WAIT;
                    end else if (rd && eoc) begin
                        den_d   = 1'b1;
                        daddr_d = ADDR_WIDTH'(channel);
                        cnt_d   = '0;
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                // rd is not consulted here: a started read always completes.
                if (drdy) begin
                    data_out_d = dout;
                    valid_d    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = IDLE;
                    end
                end
            end

            WR_WAIT: begin
                if (drdy) begin
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_adc.sv
// -----------------------------------------------------------------------------
// tb_fsm_adc
//
// Directed bench for fsm_adc. Inputs change #1 after a rising edge and outputs
// are inspected at that same point, i.e. they show the result of the edge just
// taken. DRP responses (drdy/dout) are driven by hand in the sequence.
// -----------------------------------------------------------------------------
module tb_fsm_adc;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [6:0]  addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        valid;
    logic        jtaglocked;
    logic        busy;
    logic        drdy;
    logic        eoc;
    logic        eos;
    logic [4:0]  channel;
    logic [15:0] dout;
    logic        dwe;
    logic        den;
    logic [6:0]  daddr;
    logic [15:0] din;
    logic [1:0]  state_dbg;

    int          test_cnt  = 0;
    int          fail_cnt  = 0;
    int          valid_cnt = 0;
    logic [15:0] exp_q[$];

    fsm_adc dut (
        .clk        (clk),
        .rst        (rst),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .valid      (valid),
        .jtaglocked (jtaglocked),
        .busy       (busy),
        .drdy       (drdy),
        .eoc        (eoc),
        .eos        (eos),
        .channel    (channel),
        .dout       (dout),
        .dwe        (dwe),
        .den        (den),
        .daddr      (daddr),
        .din        (din),
        .state_dbg  (state_dbg)
    );

    // Clock / reset-independent infrastructure.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) valid_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver helpers.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] rnd;
        logic [15:0] exp_word;
        int          v_before;

        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        jtaglocked = 1'b0; busy = 1'b0; drdy = 1'b0; eoc = 1'b0; eos = 1'b0;
        channel = '0; dout = '0;

        // ---- reset then idle --------------------------------------------
        steps(3);
        check("rst_den", den, 0);
        check("rst_dwe", dwe, 0);
        check("rst_valid", valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_daddr", daddr, 0);
        check("rst_din", din, 0);
        check("rst_state", state_dbg, S_IDLE);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eoc = i[0];
            eos = i[0];
            busy = ~i[0];
            step();
            check("idle_den", den, 0);
            check("idle_dwe", dwe, 0);
            check("idle_valid", valid, 0);
            check("idle_data_out", data_out, 0);
        end
        eoc = 1'b0; eos = 1'b0; busy = 1'b0;

        // ---- single read ------------------------------------------------
        rd = 1'b1; channel = 5'h10; eoc = 1'b1;
        step();
        check("rd_den", den, 1);
        check("rd_dwe", dwe, 0);
        check("rd_daddr", daddr, 7'h10);
        check("rd_state", state_dbg, S_RD);
        eoc = 1'b0;
        step();
        check("rd_den_one_cycle", den, 0);
        step();
        check("rd_no_valid_early", valid, 0);
        drdy = 1'b1; dout = 16'hABC0;
        step();
        check("rd_valid", valid, 1);
        check("rd_data_out", data_out, 16'hABC0);
        check("rd_sample12", data_out[15:4], 12'hABC);
        check("rd_state_idle", state_dbg, S_IDLE);
        drdy = 1'b0; dout = 16'h0000; rd = 1'b0;
        step();
        check("rd_valid_one_cycle", valid, 0);
        check("rd_data_hold", data_out, 16'hABC0);

        // ---- write ------------------------------------------------------
        wr = 1'b1; addr = 7'h41; data_in = 16'h2000;
        step();
        check("wr_den", den, 1);
        check("wr_dwe", dwe, 1);
        check("wr_daddr", daddr, 7'h41);
        check("wr_din", din, 16'h2000);
        check("wr_state", state_dbg, S_WR);
        wr = 1'b0; addr = 7'h00; data_in = 16'h0000;
        step();
        check("wr_den_one_cycle", den, 0);
        check("wr_dwe_one_cycle", dwe, 0);
        check("wr_din_hold", din, 16'h2000);
        drdy = 1'b1; dout = 16'h1111;
        step();
        check("wr_valid", valid, 1);
        check("wr_data_out_unchanged", data_out, 16'hABC0);
        drdy = 1'b0;
        step();
        check("wr_valid_one_cycle", valid, 0);

        // ---- drdy in IDLE is ignored -------------------------------------
        drdy = 1'b1; dout = 16'h7777;
        step();
        check("idle_drdy_valid", valid, 0);
        check("idle_drdy_data", data_out, 16'hABC0);
        drdy = 1'b0;

        // ---- priority: write wins over rd&eoc ----------------------------
        rd = 1'b1; eoc = 1'b1; channel = 5'h03;
        wr = 1'b1; addr = 7'h12; data_in = 16'h1234;
        step();
        check("prio_dwe", dwe, 1);
        check("prio_daddr", daddr, 7'h12);
        check("prio_state", state_dbg, S_WR);
        wr = 1'b0; eoc = 1'b0;
        step();
        drdy = 1'b1;
        step();
        check("prio_valid", valid, 1);
        drdy = 1'b0;
        step();
        check("prio_eoc_dropped_den", den, 0);
        check("prio_eoc_dropped_state", state_dbg, S_IDLE);

        // ---- overlap: eoc during RD_WAIT, rd dropped mid-read -----------
        eoc = 1'b1; channel = 5'h07;
        step();
        check("ovl_den", den, 1);
        check("ovl_daddr", daddr, 7'h07);
        eoc = 1'b0; rd = 1'b0;
        step();
        eoc = 1'b1; rd = 1'b1; channel = 5'h09;
        step();
        check("ovl_second_eoc_den", den, 0);
        check("ovl_daddr_hold", daddr, 7'h07);
        eoc = 1'b0; rd = 1'b0;
        drdy = 1'b1; dout = 16'h5550;
        step();
        check("ovl_valid", valid, 1);
        check("ovl_data_out", data_out, 16'h5550);
        drdy = 1'b0;
        step();
        check("ovl_no_extra_den", den, 0);
        check("ovl_state_idle", state_dbg, S_IDLE);

        // ---- timeout ----------------------------------------------------
        rd = 1'b1; eoc = 1'b1; channel = 5'h01;
        step();
        check("to_den", den, 1);
        eoc = 1'b0; rd = 1'b0;
        v_before = valid_cnt;
        steps(254);
        check("to_still_waiting", state_dbg, S_RD);
        step();
        check("to_idle_at_255", state_dbg, S_IDLE);
        check("to_no_valid", valid_cnt - v_before, 0);
        check("to_data_unchanged", data_out, 16'h5550);
        drdy = 1'b1; dout = 16'hDEAD;
        step();
        check("to_late_drdy_ignored", valid, 0);
        drdy = 1'b0;

        // ---- jtaglocked blocks accesses ---------------------------------
        jtaglocked = 1'b1; rd = 1'b1; eoc = 1'b1; wr = 1'b1;
        addr = 7'h22; data_in = 16'h4444;
        for (int i = 0; i < 3; i++) begin
            step();
            check("lock_den", den, 0);
            check("lock_state", state_dbg, S_IDLE);
        end
        jtaglocked = 1'b0; rd = 1'b0; eoc = 1'b0; wr = 1'b0;
        step();

        // ---- sampling run: 2048 eoc pulses, 26 cycles apart --------------
        rd = 1'b1;
        v_before = valid_cnt;
        for (int i = 0; i < 2048; i++) begin
            channel = 5'(i);
            eoc = 1'b1;
            step();
            check("run_den", den, 1);
            check("run_daddr", daddr, {2'b00, 5'(i)});
            eoc = 1'b0;
            step();
            rnd = 16'($urandom_range(0, 65535));
            drdy = 1'b1; dout = rnd;
            exp_q.push_back(rnd);
            step();
            exp_word = exp_q.pop_front();
            check("run_valid", valid, 1);
            check("run_data_out", data_out, exp_word);
            drdy = 1'b0;
            step();
            check("run_valid_one_cycle", valid, 0);
            steps(22);
        end
        check("run_valid_count", valid_cnt - v_before, 2048);
        check("run_queue_empty", exp_q.size(), 0);
        rd = 1'b0;

        // ---- reset during RD_WAIT ---------------------------------------
        rd = 1'b1; eoc = 1'b1; channel = 5'h02;
        step();
        check("rrst_den", den, 1);
        eoc = 1'b0;
        step();
        check("rrst_state", state_dbg, S_RD);
        #2;
        rst = 1'b0;
        #1;
        check("rrst_state_now", state_dbg, S_IDLE);
        check("rrst_data_out", data_out, 0);
        check("rrst_daddr", daddr, 0);
        check("rrst_din", din, 0);
        check("rrst_valid", valid, 0);
        step();
        rst = 1'b1; rd = 1'b0;
        drdy = 1'b1; dout = 16'hFFFF;
        v_before = valid_cnt;
        step();
        drdy = 1'b0;
        steps(2);
        check("rrst_no_valid", valid_cnt - v_before, 0);
        check("rrst_data_stays", data_out, 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/fsm_adc.md
# fsm_adc

DRP (Dynamic Reconfiguration Port) controller between the ADC capture logic and the XADC primitive wrapper. While reads are enabled, it reads each end-of-conversion result from the XADC status register of the converted channel. It returns the raw 16-bit word with a one-cycle `valid` strobe; the capture logic stores bits [15:4] as the 12-bit sample. It also performs single register writes on request.

## Interface
- `DATA_WIDTH`, default 16: DRP data width; equals ADC_WIDTH+4.
- `ADDR_WIDTH`, default 7: DRP address width.
- `TIMEOUT`, default 255: maximum cycles to wait for `drdy` before abandoning an access.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rd`  in  1  level; while high, every `eoc` triggers a DRP read.
- `wr`  in  1  write request, sampled in IDLE.
- `addr`  in  7  DRP write address.
- `data_in`  in  16  DRP write data.
- `data_out`  out  16  last word read from the DRP.
- `valid`  out  1  one-cycle strobe: a DRP access completed.
- `jtaglocked`  in  1  high blocks all new DRP accesses.
- `busy`  in  1  XADC conversion busy; informational only.
- `drdy`  in  1  DRP access complete, from the XADC.
- `eoc`  in  1  end-of-conversion pulse.
- `eos`  in  1  end-of-sequence pulse; ignored.
- `channel`  in  5  channel of the finished conversion.
- `dout`  in  16  DRP read data.
- `dwe`  out  1  DRP write enable.
- `den`  out  1  DRP enable strobe.
- `daddr`  out  7  DRP address.
- `din`  out  16  DRP write data.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT.
- All outputs are registered.
- Reset (`rst`=0) forces state IDLE. It clears `data_out`, `valid`, `den`, `dwe`, `daddr`, `din` and the timeout counter to 0.
- IDLE checks the following in priority order:
  - `jtaglocked`=1: stay in IDLE.
  - `wr`=1: set `den`=1, `dwe`=1, `daddr`=`addr`, `din`=`data_in`; go to WR_WAIT.
  - `rd`=1 and `eoc`=1: set `den`=1, `dwe`=0, `daddr`={2'b00,`channel`}; go to RD_WAIT.
- A write therefore wins over a simultaneous read trigger, and that `eoc` is lost.
- `den` and `dwe` are high for exactly one cycle. Both clear on the next edge.
- `daddr` and `din` hold their values until the next access.
- RD_WAIT:
  - On `drdy`=1: `data_out`<=`dout`, `valid`<=1, go to IDLE.
  - `eoc` pulses that arrive in this state are ignored; no queueing.
- WR_WAIT:
  - On `drdy`=1: `valid`<=1, go to IDLE.
  - `data_out` is unchanged.
- Timeout: the counter resets on entry to RD_WAIT/WR_WAIT and increments every cycle in those states.
  - When it reaches `TIMEOUT` without `drdy`: go to IDLE, no `valid`, `data_out` unchanged.
- `valid` is high for exactly one cycle.
- `drdy` seen in IDLE is ignored.
- Deasserting `rd` during RD_WAIT does not abort the read; it still completes.
- Reset mid-access aborts immediately. Outputs return to their reset values.

## Timing
- Read latency:
  - `eoc` sampled at edge N gives `den` high in cycle N..N+1.
  - `drdy` sampled at edge M gives `valid` and the new `data_out` visible after edge M, for one cycle.
- Minimum read turnaround, with `drdy` one cycle after `den`: `valid` 2 cycles after the `eoc` edge.
- Back-to-back accesses: the earliest new `den` is the cycle after `valid` (IDLE re-entered at edge M).
- Write latency: identical to read latency, measured from `wr` instead of `eoc`.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst`=0, release, hold `rd`=0 and toggle `eoc`.
  - Required: `den`, `dwe`, `valid` stay 0; `data_out`=0.
- Single read:
  - Stimulus: `rd`=1, `channel`=5'h10, `eoc` pulse; DRP model returns `dout`=16'hABC0 two cycles after `den`.
  - Required: one-cycle `den` with `dwe`=0 and `daddr`=7'h10; one-cycle `valid`; `data_out`=16'hABC0, so the sample is 12'hABC.
- Write:
  - Stimulus: `wr`=1, `addr`=7'h41, `data_in`=16'h2000.
  - Required: one-cycle `den`+`dwe`; `daddr`=7'h41, `din`=16'h2000; `valid` the cycle after `drdy`; `data_out` unchanged.
- Priority and overlap:
  - Stimulus: `wr` and `rd`&`eoc` in the same cycle, then a second `eoc` during RD_WAIT.
  - Required: the write executes and that `eoc` is dropped; the second `eoc` also produces no extra `den`.
- Timeout and lock:
  - Stimulus: withhold `drdy` after a read.
  - Required: IDLE after 255 cycles with no `valid`.
  - Stimulus: `jtaglocked`=1 with `eoc`/`wr`.
  - Required: no `den`.
- Sampling run:
  - Stimulus: `rd`=1 and 2048 `eoc` pulses spaced 26 cycles apart.
  - Required: exactly 2048 `valid` strobes, each `data_out` matching the DRP model.
- Reset during RD_WAIT:
  - Required: immediate return to the reset values; no `valid` after reset release.
